// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM state encoding and legal prescale ratios
// for the UART receive controller and its edge/bit counter.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  // Unsupported ratios fall back to the slowest legal ratio.
  function automatic int presc_legal(input int p);
    return (p == PRESC_16 || p == PRESC_32) ? p : PRESC_8;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_counter.sv
// uart_edge_bit_counter: oversample edge counter (0..P-1) and bit counter.
// Ports: clk, reset, i_en (clears when low), i_presc (P), o_edge_cnt, o_bit_cnt.
module uart_edge_bit_counter #(
  parameter int EW = 6,
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic [EW-1:0] i_presc,
  output logic [EW-1:0] o_edge_cnt,
  output logic [BW-1:0] o_bit_cnt
);

  logic [EW-1:0] r_edge;
  logic [BW-1:0] r_bit;
  logic          w_wrap;

  assign w_wrap = (r_edge == i_presc - EW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge <= '0;
      r_bit  <= '0;
    end else if (!i_en) begin
      r_edge <= '0;
      r_bit  <= '0;
    end else if (w_wrap) begin
      r_edge <= '0;
      r_bit  <= r_bit + BW'(1);
    end else begin
      r_edge <= r_edge + EW'(1);
    end
  end

  assign o_edge_cnt = r_edge;
  assign o_bit_cnt  = r_bit;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling UART receive controller (start/data/parity/stop).
// Ports: clk, reset, rx_in, prescale, par_en, par_typ -> sampled_bit,
// deser_en, data_valid, par_err, stp_err.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               par_en,
  input  logic               par_typ,
  output logic               sampled_bit,
  output logic               deser_en,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err
);

  localparam int BW = $clog2(DATA_WIDTH + 3);
  localparam logic [PRESC_W-1:0] ONE   = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] TWO   = PRESC_W'(2);
  localparam logic [PRESC_W-1:0] THREE = PRESC_W'(3);

  rx_state_e          r_state;
  rx_state_e          w_next;
  logic [PRESC_W-1:0] r_presc;
  logic               r_par_en;
  logic               r_par_typ;
  logic [2:0]         r_smp;
  logic               r_sampled;
  logic               r_xor;
  logic               r_par_err;
  logic               r_stp_err;

  logic [PRESC_W-1:0] w_edge;
  logic [BW-1:0]      w_bit;
  logic [PRESC_W-1:0] w_half;
  logic               w_cnt_en;
  logic               w_start_det;
  logic               w_bit_end;
  logic               w_at_vote;
  logic               w_at_chk;
  logic               w_last_data;
  logic               w_vote;

  uart_edge_bit_counter #(
    .EW (PRESC_W),
    .BW (BW)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_cnt_en),
    .i_presc    (r_presc),
    .o_edge_cnt (w_edge),
    .o_bit_cnt  (w_bit)
  );

  assign w_cnt_en    = (r_state != ST_IDLE);
  assign w_start_det = (r_state == ST_IDLE) && !rx_in;
  assign w_half      = r_presc >> 1;
  assign w_bit_end   = (w_edge == r_presc - ONE);
  assign w_at_vote   = (w_edge == w_half + TWO);
  assign w_at_chk    = (w_edge == w_half + THREE);
  // bit_cnt is 1 during the first data bit (START wrap bumps it).
  assign w_last_data = (w_bit == BW'(DATA_WIDTH));
  assign w_vote      = (r_smp[0] & r_smp[1]) |
                       (r_smp[0] & r_smp[2]) |
                       (r_smp[1] & r_smp[2]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    deser_en   = 1'b0;
    data_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!rx_in) w_next = ST_START;
      end
      ST_START: begin
        if (w_bit_end)
          w_next = r_sampled ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        deser_en = w_at_chk;
        if (w_bit_end && w_last_data)
          w_next = r_par_en ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (w_bit_end) w_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_end) begin
          // At P=8 the stop check and bit end share an edge, so the
          // stop condition is taken from the voted bit directly.
          data_valid = !r_par_err && r_sampled;
          w_next     = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc   <= PRESC_W'(PRESC_8);
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_smp     <= 3'b111;
      r_sampled <= 1'b1;
      r_xor     <= 1'b0;
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;
    end else begin
      if (w_start_det) begin
        r_presc   <= PRESC_W'(presc_legal(int'(prescale)));
        r_par_en  <= par_en;
        r_par_typ <= par_typ;
        r_xor     <= 1'b0;
        r_par_err <= 1'b0;
        r_stp_err <= 1'b0;
      end
      if (w_cnt_en) begin
        if (w_edge == w_half - ONE) r_smp[0] <= rx_in;
        if (w_edge == w_half)       r_smp[1] <= rx_in;
        if (w_edge == w_half + ONE) r_smp[2] <= rx_in;
        if (w_at_vote)              r_sampled <= w_vote;
      end
      if (r_state == ST_DATA && w_at_chk)
        r_xor <= r_xor ^ r_sampled;
      if (r_state == ST_PARITY && w_at_chk &&
          (r_xor ^ r_par_typ ^ r_sampled))
        r_par_err <= 1'b1;
      if (r_state == ST_STOP && w_at_chk && !r_sampled)
        r_stp_err <= 1'b1;
    end
  end

  assign sampled_bit = r_sampled;
  assign par_err     = r_par_err;
  assign stp_err     = r_stp_err;

endmodule
